// File: rtl/pulse_burst_gen_pkg.sv
// ============================================================================
//  Module   : pulse_burst_gen_pkg
//  Purpose  : Shared FSM state encoding and default width for the burst gen.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_burst_gen_pkg;

  localparam int DEFAULT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE    = 2'd1,
    ST_GAP_WAIT = 2'd2,
    ST_TRIG     = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_burst_gen_if.sv
// ============================================================================
//  Module   : pulse_burst_gen_if
//  Purpose  : Start/abort request and pulse/status bundle of pulse_burst_gen.
//             PULSE_BURST_GEN_REPEAT_EN adds the repeat_req request line.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pulse_burst_gen_if
  import pulse_burst_gen_pkg::*;
#(
  parameter int W = DEFAULT_W
);
  logic         start;
  logic [W-1:0] count;
  logic         abort;
`ifdef PULSE_BURST_GEN_REPEAT_EN
  // "repeat" is a reserved word, hence the suffix.
  logic         repeat_req;
`endif
  logic         ready;
  logic         busy;
  logic         increment;
  logic         trigger;
  logic         done;

  modport master (
    output start, count, abort,
`ifdef PULSE_BURST_GEN_REPEAT_EN
    output repeat_req,
`endif
    input  ready, busy, increment, trigger, done
  );

  modport slave (
    input  start, count, abort,
`ifdef PULSE_BURST_GEN_REPEAT_EN
    input  repeat_req,
`endif
    output ready, busy, increment, trigger, done
  );

endinterface

`default_nettype wire

// File: rtl/pulse_burst_gen_gap_timer.sv
// ============================================================================
//  Module   : pulse_gap_timer
//  Purpose  : Loadable down-counter that free-runs to zero and flags it.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_gap_timer
  import pulse_burst_gen_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_burst_gen.sv
// ============================================================================
//  Module   : pulse_burst_gen
//  Purpose  : Emits N increment pulses (GAP idle cycles after each), then one
//             trigger/done pulse. Macro PULSE_BURST_GEN_REPEAT_EN enables
//             back-to-back burst repetition.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_burst_gen
  import pulse_burst_gen_pkg::*;
#(
  parameter int W   = DEFAULT_W,
  parameter int GAP = 0
) (
  input  logic               clk,
  input  logic               rst,
  pulse_burst_gen_if.slave   bus
);

  localparam bit c_has_gap = (GAP > 0);

  state_t       r_state;
  state_t       w_next_state;
  logic [W-1:0] r_remaining;
  logic [W-1:0] w_next_remaining;
  logic         w_gap_load;
  logic         w_gap_zero;
  logic         r_ready;
  logic         r_busy;
  logic         r_increment;
  logic         r_trigger;

`ifdef PULSE_BURST_GEN_REPEAT_EN
  logic [W-1:0] r_count_latched;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count_latched <= '0;
    end else if (r_state == ST_IDLE && bus.start) begin
      r_count_latched <= bus.count;
    end
  end
`endif

  generate
    if (c_has_gap) begin : g_gap
      localparam logic [W-1:0] c_gap_load = W'(GAP - 1);

      pulse_gap_timer #(
        .W        (W)
      ) u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_gap_load),
        .load_val (c_gap_load),
        .zero     (w_gap_zero)
      );
    end else begin : g_no_gap
      // GAP_WAIT is unreachable here, so load is never raised and zero stays 1.
      assign w_gap_zero = !w_gap_load;
    end
  endgenerate

  always_comb begin
    w_next_state     = r_state;
    w_next_remaining = r_remaining;
    w_gap_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_remaining = bus.count;
          w_next_state     = (bus.count == '0) ? ST_TRIG : ST_PULSE;
        end
      end
      ST_PULSE: begin
        w_next_remaining = r_remaining - W'(1);
        if (c_has_gap) begin
          w_gap_load   = 1'b1;
          w_next_state = ST_GAP_WAIT;
        end else if (w_next_remaining == '0) begin
          w_next_state = ST_TRIG;
        end
      end
      ST_GAP_WAIT: begin
        if (w_gap_zero) begin
          w_next_state = (r_remaining == '0) ? ST_TRIG : ST_PULSE;
        end
      end
      ST_TRIG: begin
        w_next_state = ST_IDLE;
`ifdef PULSE_BURST_GEN_REPEAT_EN
        if (bus.repeat_req) begin
          w_next_remaining = r_count_latched;
          w_next_state     = (r_count_latched == '0) ? ST_TRIG : ST_PULSE;
        end
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Abort only matters once a burst is running; start wins in IDLE.
    if (bus.abort && r_state != ST_IDLE) begin
      w_next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_increment <= 1'b0;
      r_trigger   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_remaining <= w_next_remaining;
      r_ready     <= (w_next_state == ST_IDLE);
      r_busy      <= (w_next_state != ST_IDLE);
      r_increment <= (w_next_state == ST_PULSE);
      r_trigger   <= (w_next_state == ST_TRIG);
    end
  end

  assign bus.ready     = r_ready;
  assign bus.busy      = r_busy;
  assign bus.increment = r_increment;
  assign bus.trigger   = r_trigger;
  assign bus.done      = r_trigger;

endmodule

`default_nettype wire

// File: tb/tb_pulse_burst_gen.sv
// ============================================================================
//  Module   : tb_pulse_burst_gen
//  Purpose  : Directed bench for pulse_burst_gen with GAP=0 and GAP=2 copies.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_burst_gen;
  import pulse_burst_gen_pkg::*;

  localparam int TW = 16;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  pulse_burst_gen_if #(.W(TW)) bus0 ();
  pulse_burst_gen_if #(.W(TW)) bus2 ();

  pulse_burst_gen #(.W(TW), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pulse_burst_gen #(.W(TW), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Paired event counters: count increments, latch the total on trigger.
  logic          clr0, clr2;
  logic [TW-1:0] cnt0, lat0, cnt2, lat2;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0 <= '0;
      lat0 <= '0;
    end else begin
      if (clr0)                cnt0 <= '0;
      else if (bus0.increment) cnt0 <= cnt0 + 1'b1;
      if (bus0.trigger)        lat0 <= cnt0;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt2 <= '0;
      lat2 <= '0;
    end else begin
      if (clr2)                cnt2 <= '0;
      else if (bus2.increment) cnt2 <= cnt2 + 1'b1;
      if (bus2.trigger)        lat2 <= cnt2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst = 1'b0;
    clr0 = 1'b0;
    clr2 = 1'b0;
    bus0.start = 1'b0; bus0.count = '0; bus0.abort = 1'b0;
    bus2.start = 1'b0; bus2.count = '0; bus2.abort = 1'b0;
`ifdef PULSE_BURST_GEN_REPEAT_EN
    bus0.repeat_req = 1'b0;
    bus2.repeat_req = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    chk("rst_ready0", bus0.ready, 1);
    chk("rst_busy0", bus0.busy, 0);
    chk("rst_inc0", bus0.increment, 0);
    chk("rst_trig0", bus0.trigger, 0);
    chk("rst_done0", bus0.done, 0);
    chk("rst_ready2", bus2.ready, 1);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_quiet", {bus0.increment, bus0.trigger, bus2.increment, bus2.trigger}, 0);
    end

    // Back-to-back burst, N=5
    bus0.start = 1'b1; bus0.count = 16'd5; clr0 = 1'b1;
    tick();
    bus0.start = 1'b0; clr0 = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk("b2b_inc", bus0.increment, (c <= 5) ? 1 : 0);
      chk("b2b_trig", bus0.trigger, (c == 6) ? 1 : 0);
      chk("b2b_done", bus0.done, (c == 6) ? 1 : 0);
      chk("b2b_busy", bus0.busy, (c <= 6) ? 1 : 0);
      chk("b2b_ready", bus0.ready, (c == 7) ? 1 : 0);
      if (c < 7) tick();
    end
    chk("b2b_count", lat0, 5);

    // Spaced burst, GAP=2, N=3, with an ignored start at cycle 3
    bus2.start = 1'b1; bus2.count = 16'd3; clr2 = 1'b1;
    tick();
    bus2.start = 1'b0; clr2 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bus2.start = (c == 3);
      bus2.count = (c == 3) ? 16'd7 : 16'd0;
      chk("gap_inc", bus2.increment, (c == 1 || c == 4 || c == 7) ? 1 : 0);
      chk("gap_trig", bus2.trigger, (c == 10) ? 1 : 0);
      chk("gap_ready", bus2.ready, (c == 11) ? 1 : 0);
      if (c < 11) tick();
    end
    bus2.start = 1'b0;
    chk("gap_count", lat2, 3);

    // Zero-length burst
    bus0.start = 1'b1; bus0.count = 16'd0; clr0 = 1'b1;
    tick();
    bus0.start = 1'b0; clr0 = 1'b0;
    chk("zero_inc", bus0.increment, 0);
    chk("zero_trig", bus0.trigger, 1);
    chk("zero_done", bus0.done, 1);
    chk("zero_busy", bus0.busy, 1);
    tick();
    chk("zero_ready", bus0.ready, 1);
    chk("zero_trig_off", bus0.trigger, 0);
    chk("zero_count", lat0, 0);

    // Abort at cycle 40 of a 100-pulse burst
    bus0.start = 1'b1; bus0.count = 16'd100; clr0 = 1'b1;
    tick();
    bus0.start = 1'b0; clr0 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      chk("abort_inc", bus0.increment, 1);
      if (c == 40) bus0.abort = 1'b1;
      tick();
    end
    bus0.abort = 1'b0;
    chk("abort_ready", bus0.ready, 1);
    chk("abort_busy", bus0.busy, 0);
    chk("abort_inc_off", bus0.increment, 0);
    chk("abort_count", cnt0, 40);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_no_trig", {bus0.trigger, bus0.done, bus0.increment}, 0);
    end
    bus0.start = 1'b1; bus0.count = 16'd2; clr0 = 1'b1;
    tick();
    bus0.start = 1'b0; clr0 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("post_abort_inc", bus0.increment, (c <= 2) ? 1 : 0);
      chk("post_abort_trig", bus0.trigger, (c == 3) ? 1 : 0);
      tick();
    end
    chk("post_abort_count", lat0, 2);

    // Start and abort together in IDLE: start wins
    bus0.start = 1'b1; bus0.abort = 1'b1; bus0.count = 16'd1;
    tick();
    bus0.start = 1'b0; bus0.abort = 1'b0;
    chk("sa_inc", bus0.increment, 1);
    tick();
    chk("sa_trig", bus0.trigger, 1);
    chk("sa_inc_off", bus0.increment, 0);
    tick();
    chk("sa_ready", bus0.ready, 1);

    // Asynchronous reset mid-burst
    bus0.start = 1'b1; bus0.count = 16'd10;
    tick();
    bus0.start = 1'b0;
    repeat (3) tick();
    chk("ar_inc_pre", bus0.increment, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_inc", bus0.increment, 0);
    chk("ar_busy", bus0.busy, 0);
    chk("ar_ready", bus0.ready, 1);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk("ar_no_trig", {bus0.trigger, bus0.increment}, 0);
    end

`ifdef PULSE_BURST_GEN_REPEAT_EN
    // Repeating burst, N=2: inc, inc, trig, inc, inc, trig, ...
    bus0.repeat_req = 1'b1;
    bus0.start = 1'b1; bus0.count = 16'd2;
    tick();
    bus0.start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("rep_inc", bus0.increment, (c % 3 != 0) ? 1 : 0);
      chk("rep_trig", bus0.trigger, (c % 3 == 0) ? 1 : 0);
      chk("rep_busy", bus0.busy, 1);
      chk("rep_ready", bus0.ready, 0);
      tick();
    end
    bus0.abort = 1'b1; bus0.repeat_req = 1'b0;
    tick();
    bus0.abort = 1'b0;
    chk("rep_abort_ready", bus0.ready, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
